// File: rtl/morse_char_sequencer.sv
// rtl/morse_char_sequencer.sv - ASCII to Morse pattern feeder with start/done handshake and gap timing
module morse_char_sequencer #(
  parameter int unsigned UNIT_CYCLES    = 6250000,
  parameter int unsigned CHAR_GAP_UNITS = 2,
  parameter int unsigned WORD_GAP_UNITS = 4
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Char_Valid,
  input  logic [7:0] i_Char,
  output logic       o_Char_Ready,
  output logic [4:0] o_Morse_Pattern,
  output logic [2:0] o_Morse_Length,
  output logic       o_Start,
  input  logic       i_Done,
  output logic       o_Busy,
  output logic       o_Unsupported
);

  typedef enum logic [1:0] {IDLE, SEND, RELEASE, GAP} state_t;

  localparam logic [22:0] CYC_LAST = 23'(UNIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [22:0] cyc_q, cyc_d;
  logic [2:0]  unit_q, unit_d;
  logic        start_d, unsup_d, load;
  logic [4:0]  map_pattern;
  logic [2:0]  map_length;
  logic        map_symbol, map_space;
  logic [7:0]  upper;
  logic [3:0]  digit;

  assign o_Busy       = (state_q != IDLE);
  assign o_Char_Ready = (state_q == IDLE) && i_Rst_n && !i_Done;

  // Letters are case-folded; digits follow the ITU run-of-dashes structure.
  always_comb begin
    map_pattern = '0;
    map_length  = '0;
    map_symbol  = 1'b0;
    map_space   = 1'b0;
    upper       = (i_Char >= 8'h61 && i_Char <= 8'h7A) ? i_Char - 8'h20 : i_Char;
    digit       = i_Char[3:0];
    if (upper >= 8'h41 && upper <= 8'h5A) begin
      map_symbol = 1'b1;
      case (upper)
        "A": {map_pattern, map_length} = {5'b01000, 3'd2};
        "B": {map_pattern, map_length} = {5'b10000, 3'd4};
        "C": {map_pattern, map_length} = {5'b10100, 3'd4};
        "D": {map_pattern, map_length} = {5'b10000, 3'd3};
        "E": {map_pattern, map_length} = {5'b00000, 3'd1};
        "F": {map_pattern, map_length} = {5'b00100, 3'd4};
        "G": {map_pattern, map_length} = {5'b11000, 3'd3};
        "H": {map_pattern, map_length} = {5'b00000, 3'd4};
        "I": {map_pattern, map_length} = {5'b00000, 3'd2};
        "J": {map_pattern, map_length} = {5'b01110, 3'd4};
        "K": {map_pattern, map_length} = {5'b10100, 3'd3};
        "L": {map_pattern, map_length} = {5'b01000, 3'd4};
        "M": {map_pattern, map_length} = {5'b11000, 3'd2};
        "N": {map_pattern, map_length} = {5'b10000, 3'd2};
        "O": {map_pattern, map_length} = {5'b11100, 3'd3};
        "P": {map_pattern, map_length} = {5'b01100, 3'd4};
        "Q": {map_pattern, map_length} = {5'b11010, 3'd4};
        "R": {map_pattern, map_length} = {5'b01000, 3'd3};
        "S": {map_pattern, map_length} = {5'b00000, 3'd3};
        "T": {map_pattern, map_length} = {5'b10000, 3'd1};
        "U": {map_pattern, map_length} = {5'b00100, 3'd3};
        "V": {map_pattern, map_length} = {5'b00010, 3'd4};
        "W": {map_pattern, map_length} = {5'b01100, 3'd3};
        "X": {map_pattern, map_length} = {5'b10010, 3'd4};
        "Y": {map_pattern, map_length} = {5'b10110, 3'd4};
        "Z": {map_pattern, map_length} = {5'b11000, 3'd4};
        default: {map_pattern, map_length} = '0;
      endcase
    end else if (i_Char >= 8'h30 && i_Char <= 8'h39) begin
      map_symbol = 1'b1;
      map_length = 3'd5;
      if (digit <= 4'd5) map_pattern = 5'b11111 >> digit;
      else               map_pattern = 5'b11111 << (4'd10 - digit);
    end else if (i_Char == 8'h20) begin
      map_space = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = o_Start;
    cyc_d   = cyc_q;
    unit_d  = unit_q;
    unsup_d = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (o_Char_Ready && i_Char_Valid) begin
          if (map_symbol) begin
            load    = 1'b1;
            start_d = 1'b1;
            state_d = SEND;
          end else if (map_space) begin
            cyc_d   = '0;
            unit_d  = 3'(WORD_GAP_UNITS);
            state_d = GAP;
          end else begin
            unsup_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (i_Done) begin
          start_d = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!i_Done) begin
          cyc_d   = '0;
          unit_d  = 3'(CHAR_GAP_UNITS);
          state_d = GAP;
        end
      end
      GAP: begin
        start_d = 1'b0;
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          // A zero unit count is treated as a single unit rather than wrapping.
          if (unit_q <= 3'd1) begin
            unit_d  = '0;
            state_d = IDLE;
          end else begin
            unit_d = unit_q - 3'd1;
          end
        end else begin
          cyc_d = cyc_q + 23'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state_q         <= IDLE;
      cyc_q           <= '0;
      unit_q          <= '0;
      o_Start         <= 1'b0;
      o_Unsupported   <= 1'b0;
      o_Morse_Pattern <= '0;
      o_Morse_Length  <= '0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      unit_q        <= unit_d;
      o_Start       <= start_d;
      o_Unsupported <= unsup_d;
      if (load) begin
        o_Morse_Pattern <= map_pattern;
        o_Morse_Length  <= map_length;
      end
    end
  end

endmodule

// File: tb/tb_morse_char_sequencer.sv
// tb/tb_morse_char_sequencer.sv - directed scoreboard bench for morse_char_sequencer
module tb_morse_char_sequencer;
  localparam int UNIT = 4;

  logic       clk = 1'b0;
  logic       rstn, valid, done_resp, force_done, resp_en;
  logic [7:0] ch;
  logic       i_done;
  logic       o_Char_Ready, o_Start, o_Busy, o_Unsupported;
  logic [4:0] o_Morse_Pattern;
  logic [2:0] o_Morse_Length;

  int total = 0, bad = 0;
  int edge_n = 0, acc_count = 0, start_rises = 0, gap_edge = 0;
  int acc_edge[$];
  logic [7:0] exp_q[$];
  logic prev_start = 1'b0, prev_done = 1'b0, unsup_exp = 1'b0;

  string letters[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                         "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                         "..-", "...-", ".--", "-..-", "-.--", "--.."};
  string digits[10]  = '{"-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                         "---..", "----."};

  always #5 clk = ~clk;
  assign i_done = done_resp | force_done;

  morse_char_sequencer #(.UNIT_CYCLES(UNIT), .CHAR_GAP_UNITS(2), .WORD_GAP_UNITS(4)) dut (
    .i_Clock(clk), .i_Rst_n(rstn), .i_Char_Valid(valid), .i_Char(ch),
    .o_Char_Ready(o_Char_Ready), .o_Morse_Pattern(o_Morse_Pattern),
    .o_Morse_Length(o_Morse_Length), .o_Start(o_Start), .i_Done(i_done),
    .o_Busy(o_Busy), .o_Unsupported(o_Unsupported)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {is_symbol, pattern, length} built from the dot/dash text.
  function automatic logic [8:0] model(input logic [7:0] c);
    string s;
    logic [4:0] pat;
    int k;
    s = "";
    pat = '0;
    k = int'(c);
    if (k >= 97 && k <= 122) k = k - 32;
    if (k >= 65 && k <= 90) s = letters[k-65];
    else if (k >= 48 && k <= 57) s = digits[k-48];
    if (s.len() == 0) return 9'd0;
    for (int i = 0; i < s.len(); i++) if (s[i] == "-") pat[4-i] = 1'b1;
    return {1'b1, pat, 3'(s.len())};
  endfunction

  always @(posedge clk) edge_n++;

  always @(negedge clk) begin
    logic [8:0] m;
    logic [7:0] e;
    if (rstn) begin
      check("unsupported_pulse", 32'(o_Unsupported), 32'(unsup_exp));
      check("ready_rule", 32'(o_Char_Ready), 32'(!o_Busy && !i_done));
    end
    unsup_exp = 1'b0;
    if (o_Start && !prev_start) begin
      start_rises++;
      check("queue_nonempty_at_start", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pattern_length", 32'({o_Morse_Pattern, o_Morse_Length}), 32'(e));
      end
    end
    prev_start = o_Start;
    if (prev_done && !i_done) gap_edge = edge_n + 1;
    prev_done = i_done;
    if (o_Char_Ready && valid) begin
      acc_count++;
      acc_edge.push_back(edge_n + 1);
      m = model(ch);
      if (m[8]) exp_q.push_back(m[7:0]);
      else if (ch != 8'h20) unsup_exp = 1'b1;
    end
  end

  // Emulated signal stage: raises done a few cycles after start, drops it once start clears.
  initial begin
    int rs, rc;
    rs = 0; rc = 0; done_resp = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (rs)
        0: if (resp_en && o_Start) begin rs = 1; rc = 0; end
        1: begin rc++; if (rc >= 3) begin done_resp = 1'b1; rs = 2; end end
        default: if (!o_Start) begin done_resp = 1'b0; rs = 0; end
      endcase
      if (!resp_en) begin rs = 0; done_resp = 1'b0; end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (o_Busy && n < 200) begin tick(); n++; end
    check({tag, "_idle"}, 32'(o_Busy), 32'd0);
  endtask

  task automatic feed(input logic [7:0] c);
    int start = acc_count;
    int n = 0;
    ch = c;
    valid = 1'b1;
    while (acc_count == start && n < 200) begin tick(); n++; end
    check("accept_once", 32'(acc_count - start), 32'd1);
  endtask

  task automatic send(input logic [7:0] c);
    feed(c);
    valid = 1'b0;
  endtask

  initial begin
    int base_acc, base_rise, g0, sp, e2;
    rstn = 1'b0; valid = 1'b0; ch = 8'h00; force_done = 1'b0; resp_en = 1'b0;
    repeat (3) tick();
    check("rst_ready", 32'(o_Char_Ready), 32'd0);
    check("rst_start", 32'(o_Start), 32'd0);
    check("rst_pattern", 32'(o_Morse_Pattern), 32'd0);
    check("rst_length", 32'(o_Morse_Length), 32'd0);
    check("rst_unsup", 32'(o_Unsupported), 32'd0);
    check("rst_busy", 32'(o_Busy), 32'd0);

    // 'A' with hand-driven done to pin down exact timing
    rstn = 1'b1; ch = "A"; valid = 1'b1; #1;
    check("A_ready", 32'(o_Char_Ready), 32'd1);
    tick(); valid = 1'b0;
    check("A_start_rise", 32'(o_Start), 32'd1);
    check("A_pattern", 32'({o_Morse_Pattern, o_Morse_Length}), 32'({5'b01000, 3'd2}));
    tick();
    check("A_start_hold", 32'(o_Start), 32'd1);
    force_done = 1'b1;
    tick();
    check("A_start_drop", 32'(o_Start), 32'd0);
    force_done = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      check("A_gap_not_ready", 32'(o_Char_Ready), 32'd0);
      tick();
    end
    check("A_ready_after_gap", 32'(o_Char_Ready), 32'd1);

    resp_en = 1'b1;
    send("e"); wait_idle("e");
    check("e_pattern", 32'({o_Morse_Pattern, o_Morse_Length}), 32'({5'b00000, 3'd1}));
    send("E"); wait_idle("E");
    check("E_pattern", 32'({o_Morse_Pattern, o_Morse_Length}), 32'({5'b00000, 3'd1}));
    send("0"); wait_idle("zero");
    check("zero_pattern", 32'({o_Morse_Pattern, o_Morse_Length}), 32'({5'b11111, 3'd5}));
    send("T"); wait_idle("T");
    check("T_pattern", 32'({o_Morse_Pattern, o_Morse_Length}), 32'({5'b10000, 3'd1}));

    ch = "#"; valid = 1'b1;
    tick(); valid = 1'b0;
    check("hash_unsup", 32'(o_Unsupported), 32'd1);
    check("hash_no_start", 32'(o_Start), 32'd0);
    check("hash_ready", 32'(o_Char_Ready), 32'd1);
    check("hash_hold", 32'({o_Morse_Pattern, o_Morse_Length}), 32'({5'b10000, 3'd1}));
    tick();
    check("hash_unsup_end", 32'(o_Unsupported), 32'd0);

    // "E E" streamed: each IDLE visit costs one cycle before the next acceptance
    base_acc = acc_edge.size(); base_rise = start_rises;
    feed("E"); feed(" ");
    g0 = gap_edge;
    feed("E"); valid = 1'b0;
    wait_idle("EE");
    sp = acc_edge[base_acc+1]; e2 = acc_edge[base_acc+2];
    check("space_accept_delay", 32'(sp - g0), 32'd9);
    check("second_E_delay", 32'(e2 - sp), 32'd17);
    check("EE_start_count", 32'(start_rises - base_rise), 32'd2);

    // reset while '5' is being sent, with a stale done held high afterwards
    resp_en = 1'b0;
    ch = "5"; valid = 1'b1;
    tick(); valid = 1'b0;
    check("five_start", 32'(o_Start), 32'd1);
    check("five_pattern", 32'({o_Morse_Pattern, o_Morse_Length}), 32'({5'b00000, 3'd5}));
    tick();
    rstn = 1'b0;
    tick();
    check("rst_mid_start", 32'(o_Start), 32'd0);
    check("rst_mid_busy", 32'(o_Busy), 32'd0);
    check("rst_mid_ready", 32'(o_Char_Ready), 32'd0);
    force_done = 1'b1; rstn = 1'b1; ch = "T"; valid = 1'b1;
    base_acc = acc_count;
    repeat (4) begin
      tick();
      check("done_blocks_ready", 32'(o_Char_Ready), 32'd0);
    end
    check("done_blocks_accept", 32'(acc_count - base_acc), 32'd0);
    force_done = 1'b0; #1;
    check("ready_after_done_low", 32'(o_Char_Ready), 32'd1);
    tick(); valid = 1'b0;
    check("T_after_reset_start", 32'(o_Start), 32'd1);
    resp_en = 1'b1;
    wait_idle("T_after_reset");

    // backpressure: valid held high, new character on each acceptance
    base_acc = acc_count; base_rise = start_rises;
    feed("H"); feed("I"); feed(" "); feed("7"); feed("#"); feed("q");
    valid = 1'b0;
    wait_idle("stream");
    check("stream_accepts", 32'(acc_count - base_acc), 32'd6);
    check("stream_starts", 32'(start_rises - base_rise), 32'd4);
    check("stream_last_pattern", 32'({o_Morse_Pattern, o_Morse_Length}), 32'({5'b11010, 3'd4}));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
